projection_histogram_engine: RTL and testbench

- Parametrised successor of the fixed 8-bit X/Y projection histogram stage that sits after the median filter.
- Accumulates per-column (X) and per-row (Y) counts of set pixels from the filter's write stream, plus a frame total.
- Adds configurable image size and counter width, saturating counters, a frame-done boundary and back-pressured readout.
- Adds a swept clear with a completion pulse.

---
 rtl/projection_histogram_engine_pkg.sv | 18 +
 rtl/projection_histogram_engine_hist_bin_bank.sv | 53 +++++
 rtl/projection_histogram_engine.sv | 146 ++++++++++++++
 tb/tb_projection_histogram_engine.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/projection_histogram_engine_pkg.sv
// Shared types and helpers for the projection histogram engine.
// Holds the FSM encoding, the bin-count helper and the saturating increment.
package projection_histogram_engine_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StRead, StClear} state_e;

  function automatic int unsigned max_bins(int unsigned w, int unsigned h);
    return (w > h) ? w : h;
  endfunction

  // Works for any width up to 32; callers truncate the result to their own width.
  function automatic logic [31:0] sat_inc(logic [31:0] val, int unsigned width);
    logic [31:0] all_ones;
    all_ones = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (val == all_ones) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/projection_histogram_engine_hist_bin_bank.sv
// Bank of N saturating bin counters with increment, clear and combinational read ports.
// Addresses at or beyond N read back as zero and never modify state.
module projection_histogram_engine_hist_bin_bank
  import projection_histogram_engine_pkg::*;
#(
  parameter int unsigned N      = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] inc_addr,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data
);

  logic [CNT_W-1:0] bin_q [N];
  logic [CNT_W-1:0] bin_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bin_d[i] = bin_q[i];
      if (clr_en && (clr_addr == ADDR_W'(i))) begin
        bin_d[i] = '0;
      end else if (inc_en && (inc_addr == ADDR_W'(i))) begin
        bin_d[i] = CNT_W'(sat_inc(32'(bin_q[i]), CNT_W));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        bin_q[i] <= '0;
      end
    end else begin
      bin_q <= bin_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_data = bin_q[i];
      end
    end
  end

endmodule

// File: rtl/projection_histogram_engine.sv
// X/Y projection histogram: accumulates per-column and per-row set-pixel counts,
// then serves them through a back-pressured readout or zeroes them with a swept clear.
module projection_histogram_engine
  import projection_histogram_engine_pkg::*;
#(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 9,
  parameter int unsigned TOT_W  = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startHistogram,
  input  logic              frameDone,
  input  logic              pixelValid,
  input  logic [ADDR_W-1:0] xAddress,
  input  logic [ADDR_W-1:0] yAddress,
  input  logic              pixelData,
  input  logic              readHistogram,
  input  logic              clearHistogram,
  input  logic              outReady,
  output logic [ADDR_W-1:0] binIndex,
  output logic [CNT_W-1:0]  xHistogramOut,
  output logic [CNT_W-1:0]  yHistogramOut,
  output logic              xValid,
  output logic              yValid,
  output logic [TOT_W-1:0]  totalCount,
  output logic              histogramReady,
  output logic              readDone,
  output logic              histogramCleared,
  output logic              busy
);

  localparam int unsigned MaxBins = max_bins(IMG_W, IMG_H);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(MaxBins - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TOT_W-1:0]  total_q, total_d;
  logic              ready_q, ready_d;
  logic              read_done_q, read_done_d;
  logic              cleared_q, cleared_d;

  logic pix_hit, last_idx, beat, clr_en;

  assign last_idx = (idx_q == LastIdx);
  assign beat     = (state_q == StRead) && outReady;
  assign clr_en   = (state_q == StClear);
  assign pix_hit  = (state_q == StAccum) && pixelValid && pixelData &&
                    (32'(xAddress) < IMG_W) && (32'(yAddress) < IMG_H);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      total_q     <= '0;
      ready_q     <= 1'b0;
      read_done_q <= 1'b0;
      cleared_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      total_q     <= total_d;
      ready_q     <= ready_d;
      read_done_q <= read_done_d;
      cleared_q   <= cleared_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (clearHistogram)      state_d = StClear;
        else if (readHistogram)  state_d = StRead;
        else if (startHistogram) state_d = StAccum;
      end
      StAccum: if (frameDone)          state_d = StIdle;
      StRead:  if (beat && last_idx)   state_d = StIdle;
      StClear: if (last_idx)           state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    total_d     = pix_hit ? TOT_W'(sat_inc(32'(total_q), TOT_W)) : total_q;
    ready_d     = ready_q;
    read_done_d = beat && last_idx;
    cleared_d   = clr_en && last_idx;
    if (state_q == StIdle) begin
      if (clearHistogram) begin
        total_d = '0;
        ready_d = 1'b0;
      end else if (!readHistogram && startHistogram) begin
        ready_d = 1'b0;
      end
    end
    if ((state_q == StAccum) && frameDone) ready_d = 1'b1;
    // Read and clear share one sweeping index that always returns to zero.
    if (beat || clr_en) idx_d = last_idx ? '0 : idx_q + ADDR_W'(1);
  end

  always_comb begin
    busy             = (state_q != StIdle);
    binIndex         = idx_q;
    xValid           = (state_q == StRead) && (32'(idx_q) < IMG_W);
    yValid           = (state_q == StRead) && (32'(idx_q) < IMG_H);
    totalCount       = total_q;
    histogramReady   = ready_q;
    readDone         = read_done_q;
    histogramCleared = cleared_q;
  end

  projection_histogram_engine_hist_bin_bank #(
    .N      (IMG_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_x_bank (
    .clk      (clk),
    .reset    (reset),
    .inc_addr (xAddress),
    .inc_en   (pix_hit),
    .clr_addr (idx_q),
    .clr_en   (clr_en),
    .rd_addr  (idx_q),
    .rd_data  (xHistogramOut)
  );

  projection_histogram_engine_hist_bin_bank #(
    .N      (IMG_H),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_y_bank (
    .clk      (clk),
    .reset    (reset),
    .inc_addr (yAddress),
    .inc_en   (pix_hit),
    .clr_addr (idx_q),
    .clr_en   (clr_en),
    .rd_addr  (idx_q),
    .rd_data  (yHistogramOut)
  );

endmodule

// File: tb/tb_projection_histogram_engine.sv
// Directed bench for the projection histogram engine on a 4x3 image with 3-bit bins.
module tb_projection_histogram_engine;

  localparam int unsigned IMG_W  = 4;
  localparam int unsigned IMG_H  = 3;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned TOT_W  = 5;

  logic              clk = 1'b0;
  logic              reset, startHistogram, frameDone, pixelValid, pixelData;
  logic              readHistogram, clearHistogram, outReady;
  logic [ADDR_W-1:0] xAddress, yAddress, binIndex;
  logic [CNT_W-1:0]  xHistogramOut, yHistogramOut;
  logic              xValid, yValid, histogramReady, readDone, histogramCleared, busy;
  logic [TOT_W-1:0]  totalCount;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  projection_histogram_engine #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .TOT_W  (TOT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .startHistogram   (startHistogram),
    .frameDone        (frameDone),
    .pixelValid       (pixelValid),
    .xAddress         (xAddress),
    .yAddress         (yAddress),
    .pixelData        (pixelData),
    .readHistogram    (readHistogram),
    .clearHistogram   (clearHistogram),
    .outReady         (outReady),
    .binIndex         (binIndex),
    .xHistogramOut    (xHistogramOut),
    .yHistogramOut    (yHistogramOut),
    .xValid           (xValid),
    .yValid           (yValid),
    .totalCount       (totalCount),
    .histogramReady   (histogramReady),
    .readDone         (readDone),
    .histogramCleared (histogramCleared),
    .busy             (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic d);
    pixelValid = 1'b1;
    xAddress   = ADDR_W'(x);
    yAddress   = ADDR_W'(y);
    pixelData  = d;
    tick();
    pixelValid = 1'b0;
    pixelData  = 1'b0;
  endtask

  // ex holds x bins 0..3 as 3-bit fields (bin 0 in the LSBs); ey likewise for y bins 0..2.
  task automatic read_all(input string tag, input logic [11:0] ex, input logic [8:0] ey,
                          input bit stall);
    int b = 0;
    int c = 0;
    readHistogram = 1'b1;
    tick();
    readHistogram = 1'b0;
    while (b < 4 && c < 40) begin
      outReady = stall ? ((c % 3) == 0) : 1'b1;
      check($sformatf("%s_idx%0d", tag, b), binIndex, b);
      check($sformatf("%s_x%0d", tag, b), xHistogramOut, ex[b*3 +: 3]);
      check($sformatf("%s_xv%0d", tag, b), xValid, 1'b1);
      check($sformatf("%s_yv%0d", tag, b), yValid, (b < 3));
      if (b < 3) check($sformatf("%s_y%0d", tag, b), yHistogramOut, ey[b*3 +: 3]);
      check($sformatf("%s_nodone%0d", tag, b), readDone, 1'b0);
      if (outReady) b++;
      c++;
      tick();
    end
    outReady = 1'b0;
    check({tag, "_beats"}, b, 4);
    check({tag, "_done"}, readDone, 1'b1);
    check({tag, "_idle"}, busy, 1'b0);
    tick();
    check({tag, "_done_off"}, readDone, 1'b0);
  endtask

  initial begin
    reset = 1'b1; startHistogram = 0; frameDone = 0; pixelValid = 0; pixelData = 0;
    readHistogram = 0; clearHistogram = 0; outReady = 0; xAddress = 0; yAddress = 0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_ready", histogramReady, 0);
    check("rst_total", totalCount, 0);
    check("rst_index", binIndex, 0);
    check("rst_xvalid", xValid, 0);
    check("rst_yvalid", yValid, 0);
    check("rst_done", readDone, 0);
    check("rst_cleared", histogramCleared, 0);

    // Frame 1
    startHistogram = 1; tick(); startHistogram = 0;
    check("accum_busy", busy, 1);
    pix(0, 0, 1); pix(3, 2, 1); pix(3, 0, 1); pix(1, 1, 0);
    frameDone = 1; tick(); frameDone = 0;
    check("f1_total", totalCount, 3);
    check("f1_ready", histogramReady, 1);
    check("f1_idle", busy, 0);
    read_all("rd1", {3'd2, 3'd0, 3'd0, 3'd1}, {3'd1, 3'd0, 3'd2}, 1'b0);
    read_all("rd2", {3'd2, 3'd0, 3'd0, 3'd1}, {3'd1, 3'd0, 3'd2}, 1'b1);
    check("rd_nondestr_total", totalCount, 3);

    // Clear sweep, with a start attempt in the middle
    clearHistogram = 1; tick(); clearHistogram = 0;
    check("clr_total", totalCount, 0);
    check("clr_ready", histogramReady, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("clr_busy%0d", i), busy, 1);
      check($sformatf("clr_nopulse%0d", i), histogramCleared, 0);
      startHistogram = (i == 1);
      tick();
      startHistogram = 0;
    end
    check("clr_idle", busy, 0);
    check("clr_pulse", histogramCleared, 1);
    tick();
    check("clr_pulse_off", histogramCleared, 0);
    check("clr_start_ignored", busy, 0);
    read_all("rd_clr", 12'd0, 9'd0, 1'b0);

    // Saturation, out-of-range pixels, and a pixel coinciding with frameDone
    startHistogram = 1; tick(); startHistogram = 0;
    pix(5, 0, 1); pix(0, 3, 1);
    for (int i = 0; i < 8; i++) pix(2, 1, 1);
    frameDone = 1; pix(2, 1, 1); frameDone = 0;
    check("sat_total", totalCount, 9);
    check("sat_ready", histogramReady, 1);
    read_all("rd_sat", {3'd0, 3'd7, 3'd0, 3'd0}, {3'd0, 3'd7, 3'd0}, 1'b0);

    // Reset mid-READ after beat 1
    readHistogram = 1; tick(); readHistogram = 0;
    outReady = 1; tick(); tick();
    check("mid_rd_index", binIndex, 2);
    reset = 1; outReady = 0; tick(); reset = 0;
    check("rrd_busy", busy, 0);
    check("rrd_index", binIndex, 0);
    check("rrd_done", readDone, 0);
    check("rrd_total", totalCount, 0);
    tick();
    check("rrd_done2", readDone, 0);
    check("rrd_cleared2", histogramCleared, 0);

    // Reset mid-ACCUM
    startHistogram = 1; tick(); startHistogram = 0;
    pix(1, 1, 1);
    check("mid_acc_total", totalCount, 1);
    pixelValid = 1; pixelData = 1; xAddress = 2; yAddress = 2;
    reset = 1; tick(); reset = 0; pixelValid = 0; pixelData = 0;
    check("racc_busy", busy, 0);
    check("racc_total", totalCount, 0);
    tick();
    check("racc_done", readDone, 0);
    check("racc_cleared", histogramCleared, 0);
    read_all("rd_rst", 12'd0, 9'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
